// File: rtl/fft_pkg.sv
// Shared types and constants for the beat-detection FFT frame sequencer.
// Build option: FFT_LOW_ENERGY_EN (see fft_frame_ctrl).
package fft_pkg;

  localparam int DEF_N_LOG2 = 10;
  localparam int DEF_SW     = 16;
  localparam int DEF_MW     = 32;

  localparam int DC_BIN     = 0;

  typedef enum logic [2:0] {
    CONFIG,
    COLLECT,
    START,
    LOAD,
    WAIT_DONE,
    UNLOAD,
    REPORT
  } fft_state_e;

  // Nyquist bin for a 2**n_log2 point transform
  function automatic int nyquist_bin(input int n_log2);
    return 1 << (n_log2 - 1);
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Frame sample buffer: one synchronous write port, one asynchronous read port
// so the FFT core sees the sample for its requested index in the same cycle.
module frame_buf #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer between the audio source and the FFT wrapper: collect, load,
// unload, report peak bin. FFT_LOW_ENERGY_EN adds the low-band energy output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CONFIG    | program forward transform direction (we pulse follows)
// COLLECT   | accept N samples into the frame buffer
// START     | fft_start pulse is on the outputs
// LOAD      | core pulls samples by index; leaves after index N-1 with rfd
// WAIT_DONE | running peak cleared, waiting for fft_done
// UNLOAD    | scan bin stream for the peak in bins 1..N/2-1
// REPORT    | frame_valid pulse with latched peak
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = DEF_N_LOG2,
  parameter int SW     = DEF_SW,
  parameter int MW     = DEF_MW
`ifdef FFT_LOW_ENERGY_EN
  ,parameter int LOW_BINS = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [SW-1:0]     sample_data,
  output logic              sample_ready,
  output logic              fft_fwd_inv,
  output logic              fft_fwd_inv_we,
  output logic              fft_start,
  output logic [SW-1:0]     fft_xn_re,
  output logic [SW-1:0]     fft_xn_im,
  input  logic [N_LOG2-1:0] fft_xn_index,
  input  logic              fft_rfd,
  input  logic              fft_done,
  output logic              fft_unload,
  input  logic              fft_dv,
  input  logic [N_LOG2-1:0] fft_xk_index,
  input  logic [MW-1:0]     fft_magnitude,
  output logic              frame_valid,
  output logic [N_LOG2-1:0] peak_bin,
  output logic [MW-1:0]     peak_mag,
  output logic              overrun
`ifdef FFT_LOW_ENERGY_EN
  ,output logic [MW+N_LOG2-1:0] low_energy
`endif
);

  localparam logic [N_LOG2-1:0] LAST_IDX = '1;
  localparam logic [N_LOG2-1:0] DC_IDX   = N_LOG2'(DC_BIN);
  localparam logic [N_LOG2-1:0] NYQ_IDX  = N_LOG2'(nyquist_bin(N_LOG2));

  fft_state_e        state;
  logic [N_LOG2-1:0] wr_ptr;
  logic [N_LOG2-1:0] run_bin;
  logic [MW-1:0]     run_mag;
  logic              wr_en;
  logic              bin_in_band;
  logic [SW-1:0]     rd_data;
`ifdef FFT_LOW_ENERGY_EN
  logic [MW+N_LOG2-1:0] low_acc;
  logic                 bin_in_low;

  assign bin_in_low = (fft_xk_index != DC_IDX) && (fft_xk_index <= N_LOG2'(LOW_BINS));
`endif

  // Handshake is on the registered ready, so acceptance and overrun agree
  // with what the source actually sees.
  assign wr_en       = sample_ready & sample_valid;
  assign bin_in_band = (fft_xk_index != DC_IDX) && (fft_xk_index < NYQ_IDX);
  assign fft_xn_re   = (state == LOAD) ? rd_data : '0;
  assign fft_xn_im   = '0;

  frame_buf #(
    .AW (N_LOG2),
    .DW (SW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (sample_data),
    .raddr (fft_xn_index),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= CONFIG;
      wr_ptr         <= '0;
      sample_ready   <= 1'b0;
      fft_fwd_inv    <= 1'b0;
      fft_fwd_inv_we <= 1'b0;
      fft_start      <= 1'b0;
      fft_unload     <= 1'b0;
      frame_valid    <= 1'b0;
      peak_bin       <= '0;
      peak_mag       <= '0;
      run_bin        <= '0;
      run_mag        <= '0;
      overrun        <= 1'b0;
`ifdef FFT_LOW_ENERGY_EN
      low_acc        <= '0;
      low_energy     <= '0;
`endif
    end else begin
      fft_fwd_inv_we <= 1'b0;
      fft_start      <= 1'b0;
      fft_unload     <= 1'b0;
      frame_valid    <= 1'b0;

      if (sample_valid && !sample_ready) overrun <= 1'b1;

      case (state)
        CONFIG: begin
          fft_fwd_inv    <= 1'b1;
          fft_fwd_inv_we <= 1'b1;
          state          <= COLLECT;
        end

        COLLECT: begin
          sample_ready <= 1'b1;
          if (wr_en) begin
            wr_ptr <= wr_ptr + N_LOG2'(1);
            if (wr_ptr == LAST_IDX) begin
              sample_ready <= 1'b0;
              fft_start    <= 1'b1;
              state        <= START;
            end
          end
        end

        START: state <= LOAD;

        LOAD: begin
          if (fft_rfd && fft_xn_index == LAST_IDX) begin
            run_bin <= '0;
            run_mag <= '0;
`ifdef FFT_LOW_ENERGY_EN
            low_acc <= '0;
`endif
            state   <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (fft_done) begin
            fft_unload <= 1'b1;
            state      <= UNLOAD;
          end
        end

        UNLOAD: begin
          if (fft_dv) begin
            // strict greater-than keeps the lower bin on ties
            if (bin_in_band && fft_magnitude > run_mag) begin
              run_bin <= fft_xk_index;
              run_mag <= fft_magnitude;
            end
`ifdef FFT_LOW_ENERGY_EN
            if (bin_in_low) low_acc <= low_acc + (MW+N_LOG2)'(fft_magnitude);
`endif
            // last bin is always in the upper half, so running values are final
            if (fft_xk_index == LAST_IDX) begin
              peak_bin    <= run_bin;
              peak_mag    <= run_mag;
`ifdef FFT_LOW_ENERGY_EN
              low_energy  <= low_acc;
`endif
              frame_valid <= 1'b1;
              state       <= REPORT;
            end
          end
        end

        REPORT: begin
          sample_ready <= 1'b1;
          state        <= COLLECT;
        end

        default: state <= CONFIG;
      endcase
    end
  end

endmodule
